cache_4_way: RTL and testbench

//  4-way set-associative, word-addressed data cache with an integrated backing word memory.

---
 rtl/cache_4_way.sv | 132 +++++++++++++
 tb/tb_cache_4_way.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/cache_4_way.sv
// cache_4_way: 4-way set-associative, word-addressed, write-through /
// write-allocate data cache with an integrated backing word memory.
// True-LRU replacement, registered read data, one access per cycle.
// Optional feature macro: CACHE_STATS_EN adds hit / hit_count / miss_count.
module cache_4_way #(
  parameter int WORD_W = 32,
  parameter int SETS   = 8,
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] data,
  input  logic [31:0]       addr,
  input  logic              wr,
  output logic [WORD_W-1:0] q
`ifdef CACHE_STATS_EN
  ,
  output logic              hit,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = MEM_AW - IDX_W;
  localparam int WAYS  = 4;

  logic [MEM_AW-1:0] maddr;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              unused_addr;

  assign maddr       = addr[MEM_AW-1:0];
  assign idx         = maddr[IDX_W-1:0];
  assign tag         = maddr[MEM_AW-1:IDX_W];
  assign unused_addr = ^addr[31:MEM_AW];

  logic              valid_r [SETS][WAYS];
  logic [TAG_W-1:0]  tag_r   [SETS][WAYS];
  logic [WORD_W-1:0] line_r  [SETS][WAYS];
  logic [1:0]        age_r   [SETS][WAYS];
  logic [WORD_W-1:0] mem     [2**MEM_AW];

  logic [WAYS-1:0]   hit_vec;
  logic              acc_hit;
  logic [1:0]        hit_way;
  logic [1:0]        victim;
  logic [1:0]        acc_way;
  logic [1:0]        acc_age;
  logic [1:0]        new_age [WAYS];
  logic [WORD_W-1:0] mem_word;
  logic [WORD_W-1:0] fill_word;
  logic [WORD_W-1:0] rd_word;

  // Lookup, victim choice and next LRU ages for the addressed set
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    victim  = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_r[idx][w] && (tag_r[idx][w] == tag);
      if (hit_vec[w]) hit_way = 2'(w);
      if (age_r[idx][w] == 2'd3) victim = 2'(w);
    end
    // Scan downwards so the lowest-numbered invalid way wins over the oldest way
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (!valid_r[idx][WAYS-1-i]) victim = 2'(WAYS-1-i);
    end
    acc_hit = |hit_vec;
    acc_way = acc_hit ? hit_way : victim;
    acc_age = age_r[idx][acc_way];
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (2'(w) == acc_way)
        new_age[w] = 2'd0;
      else if (age_r[idx][w] < acc_age)
        new_age[w] = age_r[idx][w] + 2'd1;
      else
        new_age[w] = age_r[idx][w];
    end
    mem_word  = mem[maddr];
    fill_word = wr ? data : mem_word;
    rd_word   = acc_hit ? line_r[idx][acc_way] : mem_word;
  end

  // Backing memory: write-through of every non-reset write
  always_ff @(posedge clk) begin
    if (!rst && wr) mem[maddr] <= data;
  end

  // Line data and tags: updated on writes and on read-miss refills
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr || !acc_hit) line_r[idx][acc_way] <= fill_word;
      if (!acc_hit) tag_r[idx][acc_way] <= tag;
    end
  end

  // Valid bits, LRU ages and read data register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_r[s][w] <= 1'b0;
          age_r[s][w]   <= 2'(w);
        end
      end
      q <= '0;
    end else begin
      valid_r[idx][acc_way] <= 1'b1;
      for (int unsigned w = 0; w < WAYS; w++) begin
        age_r[idx][w] <= new_age[w];
      end
      if (!wr) q <= rd_word;
    end
  end

`ifdef CACHE_STATS_EN
  // Hit flag of the last access and wrapping hit/miss counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hit        <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      hit <= acc_hit;
      if (acc_hit) hit_count  <= hit_count + 32'd1;
      else         miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_4_way.sv
// Scoreboard bench for cache_4_way: directed scenarios then random traffic,
// checked against an LRU-list / flat-memory reference model.
module tb_cache_4_way;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr = 1'b0;
  logic [31:0] data = '0;
  logic [31:0] addr = '0;
  logic [31:0] q;
`ifdef CACHE_STATS_EN
  logic        hit;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  cache_4_way #(.WORD_W(32), .SETS(8), .MEM_AW(10)) dut (
    .clk(clk),
    .rst(rst),
    .data(data),
    .addr(addr),
    .wr(wr),
    .q(q)
`ifdef CACHE_STATS_EN
    ,
    .hit(hit),
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic        hit;
    logic [31:0] hc;
    logic [31:0] mc;
  } exp_t;

  exp_t   expq[$];
  string  nameq[$];
  int     checks = 0;
  int     failures = 0;

  // Reference model: flat memory plus, per set, a most-recent-first list of tags
  logic [31:0] mem_m [1024];
  int unsigned lru [8][$];
  logic [31:0] q_m = '0;
  logic        hit_m = 1'b0;
  logic [31:0] hc_m = '0;
  logic [31:0] mc_m = '0;

  function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endfunction

  task automatic issue(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input string nm);
    int unsigned ma, s, t;
    int found;
    exp_t e;
    @(negedge clk);
    rst = r; wr = w; addr = a; data = d;
    if (r) begin
      for (int i = 0; i < 8; i++) lru[i].delete();
      q_m = '0; hit_m = 1'b0; hc_m = '0; mc_m = '0;
    end else begin
      ma = a % 1024;
      s = ma % 8;
      t = ma / 8;
      found = -1;
      for (int i = 0; i < lru[s].size(); i++) if (lru[s][i] == t) found = i;
      if (found >= 0) lru[s].delete(found);
      else if (lru[s].size() == 4) void'(lru[s].pop_back());
      lru[s].push_front(t);
      hit_m = (found >= 0);
      if (hit_m) hc_m++; else mc_m++;
      if (w) mem_m[ma] = d;
      else q_m = mem_m[ma];
    end
    e.q = q_m; e.hit = hit_m; e.hc = hc_m; e.mc = mc_m;
    expq.push_back(e);
    nameq.push_back(nm);
  endtask

  // Monitor: one expected entry per clocked access, compared just after the edge
  initial begin
    exp_t e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        nm = nameq.pop_front();
        check({nm, "_q"}, q, e.q);
`ifdef CACHE_STATS_EN
        check({nm, "_hit"}, {31'd0, hit}, {31'd0, e.hit});
        check({nm, "_hits"}, hit_count, e.hc);
        check({nm, "_misses"}, miss_count, e.mc);
`endif
      end
    end
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) mem_m[i] = '0;
    // 1: reset, read of untouched address
    issue(1, 0, 0, 0, "t1_rst");
    issue(0, 0, 0, 0, "t1_rd0");
    // 2: write then read same address
    issue(0, 1, 0, 1, "t2_wr");
    issue(0, 0, 0, 0, "t2_rd");
    // 3: five lines into set 0, LRU eviction and refill
    issue(1, 0, 0, 0, "t3_rst");
    for (int i = 0; i < 5; i++) issue(0, 1, 32'(i * 8), 32'hA0 + 32'(i), "t3_wr");
    issue(0, 0, 0, 0, "t3_rd0");
    issue(0, 0, 8, 0, "t3_rd8");
    // 4: data survives reset in backing memory
    issue(0, 1, 5, 32'h55, "t4_wr");
    issue(1, 1, 5, 32'hDEAD, "t4_rst");
    issue(0, 0, 5, 0, "t4_rd5");
    // 5: upper address bits ignored
    issue(0, 1, 32'h0000_0403, 32'h77, "t5_wr");
    issue(0, 0, 3, 0, "t5_rd3");
    issue(0, 0, 32'hFFFF_FC03, 0, "t5_rdhi");
    // 6: hit/miss accounting after reset
    issue(1, 0, 0, 0, "t6_rst");
    issue(0, 1, 0, 1, "t6_wr");
    issue(0, 0, 0, 0, "t6_rd");
    issue(0, 0, 0, 0, "t6_rd2");
    // Random traffic, mostly within 64 words to force hits and evictions
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      issue(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), a, $urandom, "rnd");
    end
    @(negedge clk);
    rst = 1'b0; wr = 1'b0;
    repeat (3) @(negedge clk);
    check("drain", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
